// File: rtl/locked_mult_pkg.sv
// Shared types for the locked-multiplier scheduler: FSM states, default widths, latched request record.
package locked_mult_pkg;

  localparam int OP_W_DEF  = 8;
  localparam int KEY_W_DEF = 32;

  typedef enum logic [1:0] {
    S_NOKEY  = 2'd0,
    S_IDLE   = 2'd1,
    S_SETTLE = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic [OP_W_DEF-1:0] op1;
    logic [OP_W_DEF-1:0] op2;
    logic                id;
  } req_t;

endpackage

// File: rtl/lock_key_loader.sv
// Serial activation-key loader: MSB-first shadow shift register, saturating bit count, active key on commit.
// LOCKED_MULT_ZEROIZE_EN clears the shadow on commit; otherwise the shadow keeps its contents.
module lock_key_loader
  import locked_mult_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             key_bit_i,
  input  logic             shift_i,
  input  logic             commit_i,
  input  logic             clear_loaded_i,
  output logic [KEY_W-1:0] key_o,
  output logic             loaded_o,
  output logic             full_o
);

  localparam int CNT_W = $clog2(KEY_W + 1);

  logic [KEY_W-1:0] shadow_q;
  logic [KEY_W-1:0] active_q;
  logic [CNT_W-1:0] cnt_q;
  logic             loaded_q;

  assign full_o   = (cnt_q == CNT_W'(KEY_W));
  assign key_o    = active_q;
  assign loaded_o = loaded_q;

  // A shift always wins over a commit in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      loaded_q <= 1'b0;
    end else if (shift_i) begin
      shadow_q <= {shadow_q[KEY_W-2:0], key_bit_i};
      if (!full_o) cnt_q <= cnt_q + 1'b1;
      if (clear_loaded_i) loaded_q <= 1'b0;
    end else if (commit_i && full_o) begin
      active_q <= shadow_q;
      cnt_q    <= '0;
      loaded_q <= 1'b1;
`ifdef LOCKED_MULT_ZEROIZE_EN
      shadow_q <= '0;
`endif
    end
  end

endmodule

// File: rtl/locked_mult_sched.sv
// Round-robin scheduler for one shared locked 8x8 multiplier; response SETTLE_C edges after grant, held until rsp_ready_i.
// One operation in flight: requests get no ready until the response is consumed. Option: LOCKED_MULT_ZEROIZE_EN.
module locked_mult_sched
  import locked_mult_pkg::*;
#(
  parameter int OP_W     = OP_W_DEF,
  parameter int KEY_W    = KEY_W_DEF,
  parameter int SETTLE_C = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              key_bit_i,
  input  logic              key_shift_i,
  input  logic              key_commit_i,
  output logic              key_loaded_o,
  input  logic              req0_valid_i,
  input  logic [OP_W-1:0]   req0_op1_i,
  input  logic [OP_W-1:0]   req0_op2_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [OP_W-1:0]   req1_op1_i,
  input  logic [OP_W-1:0]   req1_op2_i,
  output logic              req1_ready_o,
  output logic              rsp_valid_o,
  output logic              rsp_id_o,
  output logic [2*OP_W-1:0] rsp_result_o,
  input  logic              rsp_ready_i,
  output logic [OP_W-1:0]   mul_op1_o,
  output logic [OP_W-1:0]   mul_op2_o,
  output logic [KEY_W-1:0]  mul_key_o,
  input  logic [2*OP_W-1:0] mul_result_i
);

  localparam int               CNT_W       = (SETTLE_C > 1) ? $clog2(SETTLE_C) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_C - 1);

  state_e              state_q;
  logic                last_grant_q;
  logic [CNT_W-1:0]    settle_q;
  req_t                req_q;
  logic                rsp_valid_q;
  logic                rsp_id_q;
  logic [2*OP_W-1:0]   rsp_result_q;

  logic                key_full;
  logic [KEY_W-1:0]    active_key;
  logic                shift_acc;
  logic                commit_req;
  logic                gnt_vld;
  logic                gnt_id;

  assign shift_acc  = key_shift_i && (state_q == S_NOKEY || state_q == S_IDLE);
  assign commit_req = key_commit_i && (state_q == S_NOKEY);

  lock_key_loader #(.KEY_W(KEY_W)) u_key (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .key_bit_i      (key_bit_i),
    .shift_i        (shift_acc),
    .commit_i       (commit_req),
    .clear_loaded_i (key_shift_i && (state_q == S_IDLE)),
    .key_o          (active_key),
    .loaded_o       (key_loaded_o),
    .full_o         (key_full)
  );

  // A key shift in S_IDLE takes priority over any pending request.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (state_q == S_IDLE && !key_shift_i) begin
      if (req0_valid_i && req1_valid_i) begin
        gnt_vld = 1'b1;
        gnt_id  = ~last_grant_q;
      end else if (req0_valid_i) begin
        gnt_vld = 1'b1;
      end else if (req1_valid_i) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_NOKEY;
      last_grant_q <= 1'b1;
      settle_q     <= '0;
      req_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
    end else begin
      case (state_q)
        S_NOKEY: if (commit_req && !key_shift_i && key_full) state_q <= S_IDLE;
        S_IDLE: begin
          if (key_shift_i) begin
            state_q <= S_NOKEY;
          end else if (gnt_vld) begin
            req_q.op1    <= gnt_id ? req1_op1_i : req0_op1_i;
            req_q.op2    <= gnt_id ? req1_op2_i : req0_op2_i;
            req_q.id     <= gnt_id;
            last_grant_q <= gnt_id;
            settle_q     <= SETTLE_LOAD;
            state_q      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_q == '0) begin
            rsp_result_q <= mul_result_i;
            rsp_id_q     <= req_q.id;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_NOKEY;
      endcase
    end
  end

  assign req0_ready_o = gnt_vld && !gnt_id;
  assign req1_ready_o = gnt_vld && gnt_id;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_result_o = rsp_result_q;

`ifdef LOCKED_MULT_ZEROIZE_EN
  assign mul_key_o = key_loaded_o ? active_key : '0;
  assign mul_op1_o = (state_q == S_SETTLE) ? req_q.op1 : '0;
  assign mul_op2_o = (state_q == S_SETTLE) ? req_q.op2 : '0;
`else
  assign mul_key_o = active_key;
  assign mul_op1_o = req_q.op1;
  assign mul_op2_o = req_q.op2;
`endif

endmodule

// File: tb/tb_locked_mult_sched.sv
// Self-checking bench for locked_mult_sched: vector table, multi-cycle corner sequences, randomized scoreboard run.
module tb_locked_mult_sched;
  import locked_mult_pkg::*;

  localparam int          SETTLE_C = 2;
  localparam logic [31:0] KEY      = 32'h578059CC;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        key_bit = 1'b0, key_shift = 1'b0, key_commit = 1'b0, key_loaded;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
  logic [7:0]  req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
  logic        rsp_valid, rsp_id, rsp_ready = 1'b0;
  logic [15:0] rsp_result, mul_result, prod;
  logic [7:0]  mul_op1, mul_op2;
  logic [31:0] mul_key;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Stand-in for the locked multiplier: correct product only under the right key.
  assign prod       = {8'h00, mul_op1} * {8'h00, mul_op2};
  assign mul_result = (mul_key == KEY) ? prod : (prod ^ 16'h5A3C);

  locked_mult_sched #(.OP_W(8), .KEY_W(32), .SETTLE_C(SETTLE_C)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .key_bit_i(key_bit), .key_shift_i(key_shift), .key_commit_i(key_commit), .key_loaded_o(key_loaded),
    .req0_valid_i(req0_valid), .req0_op1_i(req0_op1), .req0_op2_i(req0_op2), .req0_ready_o(req0_ready),
    .req1_valid_i(req1_valid), .req1_op1_i(req1_op1), .req1_op2_i(req1_op2), .req1_ready_o(req1_ready),
    .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_result_o(rsp_result), .rsp_ready_i(rsp_ready),
    .mul_op1_o(mul_op1), .mul_op2_o(mul_op2), .mul_key_o(mul_key), .mul_result_i(mul_result)
  );

  typedef struct {
    logic        v0, v1;
    logic [7:0]  a0, b0, a1, b1;
    logic        exp_id;
    logic [15:0] exp_res;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] key_v;
  logic        last_tb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, {27'd0, key_loaded, rsp_valid, rsp_id, req0_ready, req1_ready}, 32'd0);
    chk({tag, "_rsp_result"}, {16'd0, rsp_result}, 32'd0);
    chk({tag, "_mul_ops"}, {16'd0, mul_op1, mul_op2}, 32'd0);
    chk({tag, "_mul_key"}, mul_key, 32'd0);
  endtask

  task automatic shift_bits(input logic [31:0] k, input int n);
    for (int i = 0; i < n; i++) begin
      key_shift = 1'b1;
      key_bit   = k[31-i];
      step();
    end
    key_shift = 1'b0;
  endtask

  task automatic commit();
    key_commit = 1'b1;
    step();
    key_commit = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_grant(output logic got, output logic gid);
    got = 1'b0;
    gid = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        got = 1'b1;
        gid = req1_ready;
      end
    end
    if (!got) chk("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(output int k);
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      @(negedge clk);
      if (rsp_valid) k = i;
    end
    if (k == 0) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic got, gid;
    int   k;
    req0_valid = v.v0; req0_op1 = v.a0; req0_op2 = v.b0;
    req1_valid = v.v1; req1_op1 = v.a1; req1_op2 = v.b1;
    wait_grant(got, gid);
    if (got) chk({tag, "_grant"}, {30'd0, req0_ready, req1_ready}, v.exp_id ? 32'd1 : 32'd2);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (!got) return;
    last_tb = v.exp_id;
    wait_rsp(k);
    if (k == 0) return;
    chk({tag, "_latency"}, k, SETTLE_C + 1);
    chk({tag, "_id"}, {31'd0, rsp_id}, {31'd0, v.exp_id});
    chk({tag, "_result"}, {16'd0, rsp_result}, {16'd0, v.exp_res});
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  // Randomized run: model tracks busy/idle, round-robin winner and response timing from the rules.
  task automatic random_run(input int cycles);
    logic        pend0 = 1'b0, pend1 = 1'b0, idle_m = 1'b1, last_m, e0, e1, exp_rv;
    logic [7:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        exp_id_m = 1'b0;
    logic [15:0] exp_res_m = '0;
    int          lat = 0, served = 0;
    last_m = last_tb;
    for (int c = 0; c < cycles + 12; c++) begin
      if (c < cycles) begin
        if (!pend0 && $urandom_range(0, 2) == 0) begin
          pend0 = 1'b1; a0 = 8'($urandom); b0 = 8'($urandom);
        end
        if (!pend1 && $urandom_range(0, 2) == 0) begin
          pend1 = 1'b1; a1 = 8'($urandom); b1 = 8'($urandom);
        end
        rsp_ready = ($urandom_range(0, 3) != 0);
      end else begin
        rsp_ready = 1'b1;
      end
      req0_valid = pend0; req0_op1 = a0; req0_op2 = b0;
      req1_valid = pend1; req1_op1 = a1; req1_op2 = b1;
      @(negedge clk);
      if (!idle_m) lat++;
      exp_rv = !idle_m && (lat >= SETTLE_C + 1);
      e0 = 1'b0;
      e1 = 1'b0;
      if (idle_m) begin
        if (pend0 && pend1) begin
          e0 = last_m;
          e1 = !last_m;
        end else begin
          e0 = pend0;
          e1 = pend1;
        end
      end
      chk("rand_ready", {30'd0, req0_ready, req1_ready}, {30'd0, e0, e1});
      chk("rand_rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rv});
      if (exp_rv) begin
        chk("rand_rsp_id", {31'd0, rsp_id}, {31'd0, exp_id_m});
        chk("rand_rsp_result", {16'd0, rsp_result}, {16'd0, exp_res_m});
        if (rsp_ready) begin
          idle_m = 1'b1;
          served++;
        end
      end
      if (e0 || e1) begin
        idle_m    = 1'b0;
        lat       = 0;
        exp_id_m  = e1;
        exp_res_m = e1 ? {8'h00, a1} * {8'h00, b1} : {8'h00, a0} * {8'h00, b0};
        last_m    = e1;
        if (e1) pend1 = 1'b0;
        else    pend0 = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    chk("rand_drained_idle", {31'd0, idle_m}, 32'd1);
    if (served < 20) chk("rand_served_enough", served, 32'd20);
    last_tb = last_m;
  endtask

  initial begin
    logic got, gid;
    int   k;
    key_v   = KEY;
    last_tb = 1'b1;
    vecs[0] = '{1'b1, 1'b0, 8'h29, 8'h7A, 8'h00, 8'h00, 1'b0, 16'h138A};
    vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b1, 16'hFE01};
    vecs[2] = '{1'b1, 1'b1, 8'h11, 8'h11, 8'h89, 8'hFF, 1'b0, 16'h0121};
    vecs[3] = '{1'b1, 1'b1, 8'h11, 8'h11, 8'h89, 8'hFF, 1'b1, 16'h8877};
    vecs[4] = '{1'b1, 1'b1, 8'h11, 8'h11, 8'h89, 8'hFF, 1'b0, 16'h0121};
    vecs[5] = '{1'b1, 1'b1, 8'h11, 8'h11, 8'h89, 8'hFF, 1'b1, 16'h8877};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'hB7, 1'b1, 16'h0000};
    vecs[7] = '{1'b1, 1'b0, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b0, 16'h00FF};

    // Reset state, and no grant without a key.
    #3;
    chk_zero("reset");
    step();
    rst_n      = 1'b1;
    req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("nokey_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    end
    chk("nokey_state", 32'(dut.state_q), 32'(S_NOKEY));
    step();
    req0_valid = 1'b0;

    // Key load.
    shift_bits(key_v, 32);
    @(negedge clk);
    chk("key_before_commit", {31'd0, key_loaded}, 32'd0);
    commit();
    chk("key_loaded", {31'd0, key_loaded}, 32'd1);
    chk("key_value", mul_key, KEY);
    chk("key_state_idle", 32'(dut.state_q), 32'(S_IDLE));
    step();

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Response held under backpressure; shifts in S_RESP ignored.
    req0_valid = 1'b1; req0_op1 = 8'h80; req0_op2 = 8'h80;
    wait_grant(got, gid);
    chk("hold_grant", {31'd0, gid}, 32'd0);
    step();
    req0_valid = 1'b0;
    last_tb    = 1'b0;
    wait_rsp(k);
    chk("hold_latency", k, SETTLE_C + 1);
    req1_valid = 1'b1; req1_op1 = 8'h01; req1_op2 = 8'h02;
    for (int h = 0; h < 10; h++) begin
      key_shift = (h == 4);
      key_bit   = 1'b1;
      step();
      @(negedge clk);
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_result", {16'd0, rsp_result}, 32'h4000);
      chk("hold_no_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    end
    key_shift = 1'b0;
    chk("hold_key_loaded", {31'd0, key_loaded}, 32'd1);
    chk("hold_key_value", mul_key, KEY);
`ifdef LOCKED_MULT_ZEROIZE_EN
    chk("hold_mul_ops", {16'd0, mul_op1, mul_op2}, 32'h0);
`else
    chk("hold_mul_ops", {16'd0, mul_op1, mul_op2}, 32'h8080);
`endif
    rsp_ready  = 1'b1;
    req1_valid = 1'b0;
    step();
    rsp_ready = 1'b0;

    random_run(600);

    // Async reset while the multiplier is settling.
    req0_valid = 1'b1; req0_op1 = 8'h12; req0_op2 = 8'h34;
    wait_grant(got, gid);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("settle_op1", {24'd0, mul_op1}, 32'h12);
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    chk("midreset_state", 32'(dut.state_q), 32'(S_NOKEY));
    step();
    step();
    rst_n = 1'b1;
    step();

    // Short key, shift+commit collision, then a valid commit.
    shift_bits(key_v, 31);
    commit();
    chk("short_commit_loaded", {31'd0, key_loaded}, 32'd0);
    chk("short_commit_state", 32'(dut.state_q), 32'(S_NOKEY));
    key_shift  = 1'b1;
    key_bit    = key_v[0];
    key_commit = 1'b1;
    step();
    key_shift  = 1'b0;
    key_commit = 1'b0;
    @(negedge clk);
    chk("shift_commit_loaded", {31'd0, key_loaded}, 32'd0);
    commit();
    chk("reload_loaded", {31'd0, key_loaded}, 32'd1);
    chk("reload_key", mul_key, KEY);
    step();
    last_tb = 1'b1;
    run_vec('{1'b1, 1'b1, 8'hFF, 8'h01, 8'h33, 8'h03, 1'b0, 16'h00FF}, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
